// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared widths and operand type for the 16-bit grouped CLA adder
package cla_pkg;

  localparam int CLA_GROUP_W    = 4;
  localparam int CLA_NUM_GROUPS = 4;
  localparam int CLA_W          = CLA_GROUP_W * CLA_NUM_GROUPS;

  typedef logic [CLA_W-1:0] cla_word_t;

endpackage

// File: rtl/cla4_block.sv
// rtl/cla4_block.sv - combinational 4-bit carry-lookahead group
module cla4_block
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] s,
  output logic                   cout
);

  logic [CLA_GROUP_W-1:0] g;
  logic [CLA_GROUP_W-1:0] p;
  logic [CLA_GROUP_W:0]   c;

  // Every group carry is a flat sum of products off cin; nothing ripples inside the group.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[CLA_GROUP_W-1:0];
    cout = c[CLA_GROUP_W];
  end

endmodule

// File: rtl/cla16_ripple_adder.sv
// rtl/cla16_ripple_adder.sv - registered 16-bit adder, four CLA groups with group-level ripple; CLA16_OVF_EN adds ovf
module cla16_ripple_adder
  import cla_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      c_in,
  output cla_word_t s,
  output logic      c_out
`ifdef CLA16_OVF_EN
  ,
  output logic      ovf
`endif
);

  logic [CLA_NUM_GROUPS:0] grp_c;
  cla_word_t               sum_comb;

  assign grp_c[0] = c_in;

  genvar k;
  generate
    for (k = 0; k < CLA_NUM_GROUPS; k++) begin : g_grp
      cla4_block u_cla4 (
        .a    (a[k*CLA_GROUP_W +: CLA_GROUP_W]),
        .b    (b[k*CLA_GROUP_W +: CLA_GROUP_W]),
        .cin  (grp_c[k]),
        .s    (sum_comb[k*CLA_GROUP_W +: CLA_GROUP_W]),
        .cout (grp_c[k+1])
      );
    end
  endgenerate

  cla_word_t s_d,     s_q;
  logic      c_out_d, c_out_q;

`ifdef CLA16_OVF_EN
  logic ovf_d, ovf_q;
  logic c_into_msb;

  // Carry into bit 15 is recovered from the MSB sum bit since groups expose only their c4.
  always_comb begin
    c_into_msb = sum_comb[CLA_W-1] ^ a[CLA_W-1] ^ b[CLA_W-1];
    ovf_d      = c_into_msb ^ grp_c[CLA_NUM_GROUPS];
  end

  // Overflow flag registered alongside the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // Next-state for the result register is simply the combinational adder output.
  always_comb begin
    s_d     = sum_comb;
    c_out_d = grp_c[CLA_NUM_GROUPS];
  end

  // Result register; reset clears it immediately and discards any result in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_cla16_ripple_adder.sv
// tb/tb_cla16_ripple_adder.sv - directed self-checking bench for cla16_ripple_adder (CLA16_OVF_EN checks ovf)
module tb_cla16_ripple_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_wide = '0;
  logic [31:0] b_wide = '0;
  logic        c_in = 1'b0;
  logic [15:0] s;
  logic        c_out;
`ifdef CLA16_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla16_ripple_adder dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a_wide[15:0]),
    .b     (b_wide[15:0]),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out)
`ifdef CLA16_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic ci);
    a_wide = av;
    b_wide = bv;
    c_in   = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic ci, input logic [15:0] es, input logic ec);
    apply(av, bv, ci);
    check({tag, "_s"}, {16'h0, s}, {16'h0, es});
    check({tag, "_cout"}, {31'h0, c_out}, {31'h0, ec});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] gold;

    // reset held across an edge: outputs stay zero
    #2;
    check("rst_s", {16'h0, s}, 32'h0);
    check("rst_cout", {31'h0, c_out}, 32'h0);
    a_wide = 32'hFFFF; b_wide = 32'hFFFF; c_in = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_s", {16'h0, s}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    vec("basic1", 34783, 3443, 1'b1, 16'd38227, 1'b0);
    vec("basic2", 58783, 33, 1'b1, 16'd58817, 1'b0);
    vec("basic3", 457, 45887, 1'b0, 16'd46344, 1'b0);
    vec("trunc", 3783, 673443, 1'b0, 16'd21866, 1'b0);
    vec("ripple_all", 32'hFFFF, 32'h0000, 1'b1, 16'h0000, 1'b1);
    vec("max_sum", 32'hFFFF, 32'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    vec("grp_3_4", 32'h000F, 32'h0001, 1'b0, 16'h0010, 1'b0);
    vec("grp_7_8", 32'h00FF, 32'h0001, 1'b0, 16'h0100, 1'b0);
    vec("grp_11_12", 32'h0FFF, 32'h0001, 1'b0, 16'h1000, 1'b0);

    // mid-cycle asynchronous reset with nonzero outputs
    apply(32'h1234, 32'h1111, 1'b0);
    check("pre_rst_s", {16'h0, s}, 32'h2345);
    #2 rst = 1'b1;
    #1;
    check("async_rst_s", {16'h0, s}, 32'h0);
    check("async_rst_cout", {31'h0, c_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    vec("post_rst", 32'h8000, 32'h8001, 1'b0, 16'h0001, 1'b1);

`ifdef CLA16_OVF_EN
    vec("ovf_pos", 32'h7FFF, 32'h0001, 1'b0, 16'h8000, 1'b0);
    check("ovf_pos_flag", {31'h0, ovf}, 32'h1);
    vec("ovf_neg", 32'h8000, 32'h8000, 1'b0, 16'h0000, 1'b1);
    check("ovf_neg_flag", {31'h0, ovf}, 32'h1);
    vec("ovf_none", 32'hFFFF, 32'h0001, 1'b0, 16'h0000, 1'b1);
    check("ovf_none_flag", {31'h0, ovf}, 32'h0);
`endif

    // back-to-back random operands, one result per cycle
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom_range(0, 1));
      gold = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      apply({16'h0, ra}, {16'h0, rb}, rc);
      check("rand_sum", {15'h0, c_out, s}, {15'h0, gold});
`ifdef CLA16_OVF_EN
      check("rand_ovf", {31'h0, ovf},
            {31'h0, (ra[15] == rb[15]) && (gold[15] != ra[15])});
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
